// File: rtl/event_capture_encoder_pkg.sv
// evt_pkg: shared sizes, vector types and FSM state encoding for event_capture_encoder.
package evt_pkg;
   localparam int EVT_NR_OF_INPUTS = 21;
   localparam int EVT_INDEX_BITS = 5;
   typedef logic [EVT_NR_OF_INPUTS-1:0] evt_vec_t;
   typedef logic [EVT_INDEX_BITS-1:0] evt_idx_t;
   typedef enum logic {EVT_IDLE = 1'b0, EVT_PRESENT = 1'b1} evt_state_e;
endpackage

// File: rtl/event_capture_encoder_if.sv
// event_capture_encoder_if: event lines, capture enable and the index valid/ready handshake.
interface event_capture_encoder_if;
   import evt_pkg::*;
   evt_vec_t Inputs;
   logic Enable;
   logic Event_Valid;
   evt_idx_t Event_Index;
   logic Event_Ready;
   evt_vec_t Pending;
   logic Any_Pending;
   logic Overrun;
   modport master (
      input Inputs, Enable, Event_Ready,
      output Event_Valid, Event_Index, Pending, Any_Pending, Overrun
   );
   modport slave (
      output Inputs, Enable, Event_Ready,
      input Event_Valid, Event_Index, Pending, Any_Pending, Overrun
   );
endinterface

// File: rtl/evt_priority_encoder.sv
// evt_priority_encoder: find first set bit of req, searching upward from offset with wrap-around.
module evt_priority_encoder
   import evt_pkg::*;
(
   input  evt_vec_t req,
   input  evt_idx_t offset,
   output evt_idx_t idx,
   output logic     found
);
   logic [EVT_INDEX_BITS:0] j;
   // Scan from the far end back so the bit nearest the offset is written last and wins.
   always_comb begin
      idx = '0;
      found = 1'b0;
      j = '0;
      for (int i = EVT_NR_OF_INPUTS - 1; i >= 0; i--) begin
         j = {1'b0, offset} + (EVT_INDEX_BITS + 1)'(i);
         j = j >= (EVT_INDEX_BITS + 1)'(EVT_NR_OF_INPUTS) ? j - (EVT_INDEX_BITS + 1)'(EVT_NR_OF_INPUTS) : j;
         if (req[j[EVT_INDEX_BITS-1:0]]) begin
            idx = j[EVT_INDEX_BITS-1:0];
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/event_capture_encoder.sv
// event_capture_encoder: sticky capture of 21 polarity-adjusted event lines, one index presented at a time.
// Define EVT_ROUND_ROBIN_EN to search from the last accepted index + 1 instead of fixed lowest-index priority.
module event_capture_encoder
   import evt_pkg::*;
#(
   parameter int NrOfInputs = EVT_NR_OF_INPUTS,
   parameter logic [EVT_NR_OF_INPUTS-1:0] BubblesMask = '0,
   parameter logic [EVT_NR_OF_INPUTS-1:0] EdgeMask = '0,
   parameter int IndexBits = EVT_INDEX_BITS
) (
   input logic GlobalClock,
   input logic Reset_n,
   event_capture_encoder_if.master bus
);
   logic [NrOfInputs-1:0] s_real, rise, set, clr;
   logic [NrOfInputs-1:0] s_prev_q, s_prev_d, pending_q, pending_d;
   logic [IndexBits-1:0] index_q, index_d, sel_index, offset;
   logic overrun_q, overrun_d, accept, found;
   evt_state_e state_q, state_d;

   evt_priority_encoder u_enc (
      .req    (pending_q),
      .offset (offset),
      .idx    (sel_index),
      .found  (found)
   );

`ifdef EVT_ROUND_ROBIN_EN
   logic [IndexBits-1:0] ptr_q, ptr_d;
   always_comb begin
      ptr_d = accept ? (index_q == IndexBits'(NrOfInputs - 1) ? '0 : index_q + IndexBits'(1)) : ptr_q;
   end
   always_ff @(posedge GlobalClock) begin
      ptr_q <= !Reset_n ? '0 : ptr_d;
   end
   assign offset = ptr_q;
`else
   assign offset = '0;
`endif

   // A set in the same cycle as the clear of that bit re-arms it.
   always_comb begin
      s_real = bus.Inputs ^ BubblesMask;
      s_prev_d = s_real;
      rise = s_real & ~s_prev_q;
      set = bus.Enable ? (EdgeMask & rise) | (~EdgeMask & s_real) : '0;
      accept = (state_q == EVT_PRESENT) & bus.Event_Ready;
      clr = '0;
      clr[index_q] = accept;
      pending_d = (pending_q & ~clr) | set;
      overrun_d = overrun_q | (|(EdgeMask & set & pending_q & ~clr));
      state_d = state_q == EVT_IDLE ? (found ? EVT_PRESENT : EVT_IDLE) : (accept ? EVT_IDLE : EVT_PRESENT);
      index_d = (state_q == EVT_IDLE && found) ? sel_index : index_q;
   end

   always_ff @(posedge GlobalClock) begin
      s_prev_q <= s_prev_d;
      if (!Reset_n) begin
         pending_q <= '0;
         overrun_q <= 1'b0;
         state_q <= EVT_IDLE;
         index_q <= '0;
      end else begin
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         state_q <= state_d;
         index_q <= index_d;
      end
   end

   assign bus.Event_Valid = state_q == EVT_PRESENT;
   assign bus.Event_Index = index_q;
   assign bus.Pending = pending_q;
   assign bus.Any_Pending = |pending_q;
   assign bus.Overrun = overrun_q;
endmodule

// File: tb/tb_event_capture_encoder.sv
// tb_event_capture_encoder: directed scenarios plus randomized traffic against a behavioural model.
module tb_event_capture_encoder;
   import evt_pkg::*;
   localparam logic [20:0] BUB = 21'h002001;
   localparam logic [20:0] EDG = 21'h003021;
`ifdef EVT_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int checks = 0;
   int errors = 0;

   event_capture_encoder_if bus ();

   event_capture_encoder #(
      .BubblesMask (BUB),
      .EdgeMask    (EDG)
   ) dut (
      .GlobalClock (clk),
      .Reset_n     (rst_n),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // Behavioural reference: pending set, sticky overrun, and the currently offered index.
   logic [20:0] m_pend, m_prev, ms, mset, mclr;
   logic m_ovr, m_valid;
   logic [4:0] m_idx;
   int m_ptr;

   function automatic int pick(logic [20:0] p, int start);
      for (int k = 0; k < 21; k++) if (p[(start + k) % 21]) return (start + k) % 21;
      return 0;
   endfunction

   always @(posedge clk) begin
      ms = bus.Inputs ^ BUB;
      mset = bus.Enable ? ((EDG & ms & ~m_prev) | (~EDG & ms)) : '0;
      mclr = '0;
      if (m_valid && bus.Event_Ready) mclr[m_idx] = 1'b1;
      m_prev <= ms;
      if (!rst_n) begin
         m_pend <= '0;
         m_ovr <= 1'b0;
         m_valid <= 1'b0;
         m_idx <= '0;
         m_ptr <= 0;
      end else begin
         m_pend <= (m_pend & ~mclr) | mset;
         if (|(EDG & mset & m_pend & ~mclr)) m_ovr <= 1'b1;
         if (m_valid) begin
            if (bus.Event_Ready) begin
               m_valid <= 1'b0;
               m_ptr <= (int'(m_idx) + 1) % 21;
            end
         end else if (m_pend != 0) begin
            m_valid <= 1'b1;
            m_idx <= 5'(pick(m_pend, RR ? m_ptr : 0));
         end
      end
   end

   task automatic drain(input int n);
      bus.Inputs = BUB;
      bus.Enable = 1'b1;
      bus.Event_Ready = 1'b1;
      repeat (n) @(negedge clk);
      bus.Event_Ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.Inputs = BUB | 21'h000004;
      bus.Enable = 1'b1;
      bus.Event_Ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.Pending !== 21'h0 || bus.Event_Valid !== 1'b0 || bus.Event_Index !== 5'd0 ||
          bus.Overrun !== 1'b0 || bus.Any_Pending !== 1'b0) begin
         errors++;
         $display("FAIL reset_state pend=%h valid=%b idx=%0d ovr=%b any=%b, want all zero",
                  bus.Pending, bus.Event_Valid, bus.Event_Index, bus.Overrun, bus.Any_Pending);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.Pending !== 21'h4 || bus.Event_Valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_capture pend=%h valid=%b, want 000004 0", bus.Pending, bus.Event_Valid);
      end
      @(negedge clk);
      checks++;
      if (bus.Event_Valid !== 1'b1 || bus.Event_Index !== 5'd2) begin
         errors++;
         $display("FAIL reset_present valid=%b idx=%0d, want 1 2", bus.Event_Valid, bus.Event_Index);
      end
      bus.Inputs = BUB;
      bus.Event_Ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.Event_Valid !== 1'b0 || bus.Pending !== 21'h0) begin
         errors++;
         $display("FAIL reset_accept valid=%b pend=%h, want 0 000000", bus.Event_Valid, bus.Pending);
      end
      drain(4);
   endtask

   task automatic test_priority_hold();
      bus.Inputs = BUB | 21'h000088;
      bus.Event_Ready = 1'b0;
      @(negedge clk);
      bus.Inputs = BUB;
      checks++;
      if (bus.Pending !== 21'h88) begin
         errors++;
         $display("FAIL prio_pending got %h want 000088", bus.Pending);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (bus.Event_Valid !== 1'b1 || bus.Event_Index !== 5'd3) begin
            errors++;
            $display("FAIL prio_hold cycle %0d valid=%b idx=%0d, want 1 3", c, bus.Event_Valid, bus.Event_Index);
         end
      end
      bus.Event_Ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.Event_Valid !== 1'b0 || bus.Pending !== 21'h80) begin
         errors++;
         $display("FAIL prio_first_accept valid=%b pend=%h, want 0 000080", bus.Event_Valid, bus.Pending);
      end
      @(negedge clk);
      checks++;
      if (bus.Event_Valid !== 1'b1 || bus.Event_Index !== 5'd7) begin
         errors++;
         $display("FAIL prio_second valid=%b idx=%0d, want 1 7", bus.Event_Valid, bus.Event_Index);
      end
      drain(4);
   endtask

   task automatic test_edge_bubble();
      int seen = 0;
      bus.Inputs = BUB & ~21'h000001;
      bus.Event_Ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.Pending !== 21'h1) begin
         errors++;
         $display("FAIL edge_capture pend=%h want 000001", bus.Pending);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.Event_Valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 1) begin
         errors++;
         $display("FAIL edge_single_capture presented %0d times, want 1", seen);
      end
      checks++;
      if (bus.Pending !== 21'h0 || bus.Overrun !== 1'b0) begin
         errors++;
         $display("FAIL edge_quiet pend=%h ovr=%b, want 000000 0", bus.Pending, bus.Overrun);
      end
      drain(4);
   endtask

   task automatic test_enable_mid_handshake();
      bus.Inputs = BUB | 21'h000010;
      bus.Event_Ready = 1'b0;
      @(negedge clk);
      bus.Inputs = BUB;
      @(negedge clk);
      checks++;
      if (bus.Event_Valid !== 1'b1 || bus.Event_Index !== 5'd4) begin
         errors++;
         $display("FAIL enable_present valid=%b idx=%0d, want 1 4", bus.Event_Valid, bus.Event_Index);
      end
      bus.Enable = 1'b0;
      bus.Inputs = BUB | 21'h000040;
      bus.Event_Ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.Event_Valid !== 1'b0 || bus.Pending !== 21'h0) begin
         errors++;
         $display("FAIL enable_blocked valid=%b pend=%h, want 0 000000", bus.Event_Valid, bus.Pending);
      end
      drain(4);
   endtask

   task automatic test_overrun();
      bus.Inputs = BUB | 21'h000020;
      bus.Event_Ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.Pending[5] !== 1'b1 || bus.Overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_first pend5=%b ovr=%b, want 1 0", bus.Pending[5], bus.Overrun);
      end
      bus.Inputs = BUB;
      @(negedge clk);
      bus.Inputs = BUB | 21'h000020;
      @(negedge clk);
      checks++;
      if (bus.Overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set got %b want 1", bus.Overrun);
      end
      drain(6);
      checks++;
      if (bus.Overrun !== 1'b1 || bus.Pending !== 21'h0) begin
         errors++;
         $display("FAIL overrun_sticky ovr=%b pend=%h, want 1 000000", bus.Overrun, bus.Pending);
      end
   endtask

   task automatic test_reset_mid_handshake();
      bus.Inputs = BUB | 21'h000008;
      bus.Event_Ready = 1'b0;
      @(negedge clk);
      bus.Inputs = BUB;
      @(negedge clk);
      checks++;
      if (bus.Event_Valid !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_present valid=%b want 1", bus.Event_Valid);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (bus.Event_Valid !== 1'b0 || bus.Pending !== 21'h0 || bus.Overrun !== 1'b0 || bus.Event_Index !== 5'd0) begin
         errors++;
         $display("FAIL rstmid_cleared valid=%b pend=%h ovr=%b idx=%0d, want 0 000000 0 0",
                  bus.Event_Valid, bus.Pending, bus.Overrun, bus.Event_Index);
      end
      drain(3);
   endtask

   task automatic test_selection_order();
      int got[$];
      rst_n = 1'b0;
      bus.Inputs = BUB;
      @(negedge clk);
      rst_n = 1'b1;
      bus.Inputs = BUB | 21'h100002;
      bus.Event_Ready = 1'b1;
      for (int c = 0; c < 40 && got.size() < 4; c++) begin
         @(negedge clk);
         if (bus.Event_Valid === 1'b1) got.push_back(int'(bus.Event_Index));
      end
      checks++;
      if (got.size() != 4) begin
         errors++;
         $display("FAIL select_timeout accepted %0d events, want 4", got.size());
      end
      for (int k = 0; k < got.size(); k++) begin
         checks++;
         if (got[k] != ((k % 2 == 1 && RR) ? 20 : 1)) begin
            errors++;
            $display("FAIL select_order accept %0d idx=%0d want %0d", k, got[k], (k % 2 == 1 && RR) ? 20 : 1);
         end
      end
      drain(4);
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         checks++;
         if (bus.Pending !== m_pend || bus.Any_Pending !== (|m_pend) || bus.Overrun !== m_ovr ||
             bus.Event_Valid !== m_valid || (m_valid && bus.Event_Index !== m_idx)) begin
            errors++;
            $display("FAIL random cycle %0d pend=%h any=%b ovr=%b valid=%b idx=%0d, want %h %b %b %b %0d",
                     c, bus.Pending, bus.Any_Pending, bus.Overrun, bus.Event_Valid, bus.Event_Index,
                     m_pend, |m_pend, m_ovr, m_valid, m_idx);
         end
         rst_n = $urandom_range(0, 63) != 0;
         bus.Enable = $urandom_range(0, 7) != 0;
         bus.Event_Ready = 1'($urandom_range(0, 1));
         bus.Inputs = BUB ^ (21'($urandom) & 21'($urandom) & 21'($urandom) & 21'($urandom));
      end
      rst_n = 1'b1;
      drain(4);
   endtask

   initial begin
      test_reset();
      test_priority_hold();
      test_edge_bubble();
      test_enable_mid_handshake();
      test_overrun();
      test_reset_mid_handshake();
      test_selection_order();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
